elevator_call_scheduler: RTL and testbench
==========================================

// Module: elevator_call_scheduler
// PURPOSE
//  - Latches floor-call button presses and selects the next target floor for elevator_controller.
//  - Uses the LOOK algorithm: keep the current direction while calls remain ahead; reverse only when none do.
//  - Sits between the call buttons and the controller: consumes current_floor and served, drives target_floor, target_valid and sched_dir.
// PARAMETERS
//  - NUM_FLOORS  4                     number of floors; floor 0 is the lobby.
//  - FLOOR_W     $clog2(NUM_FLOORS)    width of floor indices.
// PORTS
//  - clk            in   1           single clock; all state updates on the rising edge.
//  - rst_n          in   1           asynchronous, active-low reset.
//  - call_btn       in   NUM_FLOORS  level or pulse; bit f high means a call for floor f.
//  - current_floor  in   FLOOR_W     car position reported by the controller.
//  - served         in   1           1-cycle pulse: doors opened at current_floor.
//  - emerg_recall   in   1           present only under EMERG_RECALL_EN; level.
//  - target_floor   out  FLOOR_W     floor the car should travel to.
//  - target_valid   out  1           target_floor is meaningful.
//  - sched_dir      out  2           2'b00 IDLE, 2'b01 UP, 2'b10 DOWN.
//  - pending        out  NUM_FLOORS  latched, not-yet-served calls.
//  - recall_active  out  1           present only under EMERG_RECALL_EN.
// BEHAVIOUR
//  - Reset (asynchronous, immediate, including mid-trip):
//    - pending=0, target_floor=0, target_valid=0, sched_dir=IDLE, state=S_IDLE.
//    - All latched calls are discarded.
//  - Pending update each cycle: pending <= (pending | call_btn) & ~clr.
//    - clr is a one-hot of current_floor when served=1, else 0.
//    - A press of current_floor in the same cycle as served is absorbed (clear wins).
//    - served with no pending bit for that floor: no effect.
//  - All outputs are registered. Latency: call_btn at edge N -> pending at N+1 -> target_floor/target_valid at N+2.
//  - FSM states S_IDLE, S_UP, S_DOWN; sched_dir mirrors the state. "above" and "below" are strict, relative to current_floor.
//    - S_IDLE, pending==0: target_valid=0.
//    - S_IDLE, current_floor pending: target=current_floor, stay S_IDLE.
//    - S_IDLE, otherwise: target=nearest pending floor; on an equal-distance tie choose the lower floor.
//      Go to S_UP if the target is above, else S_DOWN.
//    - S_UP, any pending above: target=lowest pending above.
//    - S_UP, else any pending below: go to S_DOWN; target=highest pending below.
//    - S_UP, else current_floor pending: target=current_floor.
//    - S_UP, else: go to S_IDLE; target_valid=0; target_floor holds its last value.
//    - S_DOWN: mirror of S_UP (highest pending below first, then reverse).
//  - target_floor may change while target_valid=1 as new calls arrive. A call ahead of the car in the current direction preempts a farther target.
//  - A call behind the car never reverses direction while calls remain ahead.
//  - current_floor >= NUM_FLOORS (non-power-of-2 NUM_FLOORS): treated as NUM_FLOORS-1.
// CONFIGURATION
//  - Macro EMERG_RECALL_EN, when defined:
//    - emerg_recall=1 forces target_floor=0, target_valid=1, recall_active=1.
//    - sched_dir=DOWN, or IDLE if current_floor==0.
//    - call_btn is ignored and pending is cleared; served has no effect on scheduling.
//    - On deassertion: recall_active=0 next cycle, state=S_IDLE, normal scheduling resumes with an empty pending set.
//  - Macro undefined: emerg_recall and recall_active ports do not exist; behaviour is the base behaviour above.
// STRUCTURE
//  - Package elevator_pkg holds:
//    - dir_t enum (DIR_IDLE=2'b00, DIR_UP=2'b01, DIR_DOWN=2'b10), shared with elevator_controller.
//    - sched_state_t enum.
//    - Default NUM_FLOORS constant.
//  - Sub-module elevator_look_picker: combinational; inputs pending and current_floor.
//    - Outputs: any_above, any_below, lowest_above, highest_below, nearest (tie -> lower).
//  - Top level holds the pending register, the FSM and the output registers.
// TESTING
//  - Reset: hold rst_n=0, pulse call_btn=4'b1111 -> pending=0, target_valid=0, sched_dir=00. Assert rst_n mid-trip -> same values immediately.
//  - Basic call: car at 0, call_btn=4'b0100 for 1 cycle -> pending=0100 after 1 cycle; target_floor=2, target_valid=1, sched_dir=UP after 2.
//  - LOOK preempt: UP toward 3 from floor 1; press floor 2 -> target_floor=2.
//    served at floor 2 -> pending=1000, target_floor=3. Floor 0 pressed meanwhile stays pending until after 3 is served, then sched_dir=DOWN, target_floor=0.
//  - Tie/served: idle at floor 1, pending=0101 -> target_floor=0, DOWN.
//    Press floor 1 in the same cycle as served at floor 1 -> bit 1 stays 0.
//    Last call served -> sched_dir=IDLE, target_valid=0.
//  - EMERG_RECALL_EN: at floor 3 with pending=0011, assert emerg_recall -> target_floor=0, pending=0, recall_active=1.
//    Presses ignored while asserted; after release, a new press of floor 2 is scheduled normally.

Source files
------------

// File: rtl/elevator_pkg.sv
`default_nettype none
// ============================================================================
// Module      : elevator_pkg
// Description : Shared types and defaults for the elevator scheduler/controller.
// Revision    : 1.0 - initial release
// ============================================================================
package elevator_pkg;

    localparam int c_NUM_FLOORS_DEFAULT = 4;

    typedef enum logic [1:0] {
        DIR_IDLE = 2'b00,
        DIR_UP   = 2'b01,
        DIR_DOWN = 2'b10
    } dir_t;

    typedef enum logic [1:0] {
        S_IDLE = 2'b00,
        S_UP   = 2'b01,
        S_DOWN = 2'b10
    } sched_state_t;

    function automatic dir_t state_to_dir(input sched_state_t s);
        case (s)
            S_UP:    return DIR_UP;
            S_DOWN:  return DIR_DOWN;
            default: return DIR_IDLE;
        endcase
    endfunction

endpackage
`default_nettype wire

// File: rtl/elevator_look_picker.sv
`default_nettype none
// ============================================================================
// Module      : elevator_look_picker
// Description : Combinational search of pending calls relative to the car.
// Revision    : 1.0 - initial release
// ============================================================================
module elevator_look_picker #(
    parameter int NUM_FLOORS = 4,
    parameter int FLOOR_W    = $clog2(NUM_FLOORS)
) (
    input  logic [NUM_FLOORS-1:0] pending,
    input  logic [FLOOR_W-1:0]    current_floor,
    output logic                  any_above,
    output logic                  any_below,
    output logic [FLOOR_W-1:0]    lowest_above,
    output logic [FLOOR_W-1:0]    highest_below,
    output logic [FLOOR_W-1:0]    nearest
);

    logic [FLOOR_W-1:0] w_dist_up;
    logic [FLOOR_W-1:0] w_dist_dn;

    // Scan direction makes the last hit the closest one on each side.
    always_comb begin
        any_above     = 1'b0;
        any_below     = 1'b0;
        lowest_above  = '0;
        highest_below = '0;
        for (int f = NUM_FLOORS - 1; f >= 0; f--) begin
            if (pending[f] && (FLOOR_W'(f) > current_floor)) begin
                any_above    = 1'b1;
                lowest_above = FLOOR_W'(f);
            end
        end
        for (int f = 0; f < NUM_FLOORS; f++) begin
            if (pending[f] && (FLOOR_W'(f) < current_floor)) begin
                any_below     = 1'b1;
                highest_below = FLOOR_W'(f);
            end
        end
    end

    assign w_dist_up = lowest_above - current_floor;
    assign w_dist_dn = current_floor - highest_below;

    // Equal distance resolves to the floor below (the lower one).
    always_comb begin
        nearest = highest_below;
        if (!any_below) begin
            nearest = lowest_above;
        end else if (any_above && (w_dist_up < w_dist_dn)) begin
            nearest = lowest_above;
        end
    end

endmodule
`default_nettype wire

// File: rtl/elevator_call_scheduler.sv
`default_nettype none
// ============================================================================
// Module      : elevator_call_scheduler
// Description : Latches floor calls and picks the next target using LOOK.
//               Optional emergency recall to the lobby under EMERG_RECALL_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module elevator_call_scheduler
    import elevator_pkg::*;
#(
    parameter int NUM_FLOORS = c_NUM_FLOORS_DEFAULT,
    parameter int FLOOR_W    = $clog2(NUM_FLOORS)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [NUM_FLOORS-1:0] call_btn,
    input  logic [FLOOR_W-1:0]    current_floor,
    input  logic                  served,
`ifdef EMERG_RECALL_EN
    input  logic                  emerg_recall,
    output logic                  recall_active,
`endif
    output logic [FLOOR_W-1:0]    target_floor,
    output logic                  target_valid,
    output logic [1:0]            sched_dir,
    output logic [NUM_FLOORS-1:0] pending
);

    sched_state_t          r_state, w_state_nxt;
    dir_t                  r_dir, w_dir_nxt;
    logic [NUM_FLOORS-1:0] r_pending, w_pending_nxt, w_clr;
    logic [FLOOR_W-1:0]    r_target, w_target_nxt, w_cur;
    logic                  r_valid, w_valid_nxt, w_cur_pending;
    logic                  w_any_above, w_any_below;
    logic [FLOOR_W-1:0]    w_lowest_above, w_highest_below, w_nearest;

    // Out-of-range floor codes only exist when NUM_FLOORS is not a power of two.
    generate
        if (NUM_FLOORS == (1 << FLOOR_W)) begin : g_cur_direct
            assign w_cur = current_floor;
        end else begin : g_cur_clamp
            assign w_cur = (current_floor > FLOOR_W'(NUM_FLOORS - 1)) ?
                           FLOOR_W'(NUM_FLOORS - 1) : current_floor;
        end
    endgenerate

    assign w_clr         = served ? (NUM_FLOORS'(1) << w_cur) : '0;
    assign w_cur_pending = r_pending[w_cur];

    elevator_look_picker #(
        .NUM_FLOORS (NUM_FLOORS),
        .FLOOR_W    (FLOOR_W)
    ) u_picker (
        .pending       (r_pending),
        .current_floor (w_cur),
        .any_above     (w_any_above),
        .any_below     (w_any_below),
        .lowest_above  (w_lowest_above),
        .highest_below (w_highest_below),
        .nearest       (w_nearest)
    );

    always_comb begin
        w_state_nxt   = r_state;
        w_target_nxt  = r_target;
        w_valid_nxt   = r_valid;
        w_pending_nxt = (r_pending | call_btn) & ~w_clr;
        case (r_state)
            S_IDLE: begin
                if (r_pending == '0) begin
                    w_valid_nxt = 1'b0;
                end else if (w_cur_pending) begin
                    w_target_nxt = w_cur;
                    w_valid_nxt  = 1'b1;
                end else begin
                    w_target_nxt = w_nearest;
                    w_valid_nxt  = 1'b1;
                    w_state_nxt  = (w_nearest > w_cur) ? S_UP : S_DOWN;
                end
            end
            S_UP: begin
                w_valid_nxt = 1'b1;
                if (w_any_above) begin
                    w_target_nxt = w_lowest_above;
                end else if (w_any_below) begin
                    w_state_nxt  = S_DOWN;
                    w_target_nxt = w_highest_below;
                end else if (w_cur_pending) begin
                    w_target_nxt = w_cur;
                end else begin
                    w_state_nxt = S_IDLE;
                    w_valid_nxt = 1'b0;
                end
            end
            S_DOWN: begin
                w_valid_nxt = 1'b1;
                if (w_any_below) begin
                    w_target_nxt = w_highest_below;
                end else if (w_any_above) begin
                    w_state_nxt  = S_UP;
                    w_target_nxt = w_lowest_above;
                end else if (w_cur_pending) begin
                    w_target_nxt = w_cur;
                end else begin
                    w_state_nxt = S_IDLE;
                    w_valid_nxt = 1'b0;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
                w_valid_nxt = 1'b0;
            end
        endcase
        w_dir_nxt = state_to_dir(w_state_nxt);
`ifdef EMERG_RECALL_EN
        // Recall overrides everything and leaves the FSM idle for a clean restart.
        if (emerg_recall) begin
            w_pending_nxt = '0;
            w_state_nxt   = S_IDLE;
            w_target_nxt  = '0;
            w_valid_nxt   = 1'b1;
            w_dir_nxt     = (w_cur == '0) ? DIR_IDLE : DIR_DOWN;
        end
`endif
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= S_IDLE;
            r_dir     <= DIR_IDLE;
            r_pending <= '0;
            r_target  <= '0;
            r_valid   <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_dir     <= w_dir_nxt;
            r_pending <= w_pending_nxt;
            r_target  <= w_target_nxt;
            r_valid   <= w_valid_nxt;
        end
    end

`ifdef EMERG_RECALL_EN
    logic r_recall;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_recall <= 1'b0;
        end else begin
            r_recall <= emerg_recall;
        end
    end

    assign recall_active = r_recall;
`endif

    assign target_floor = r_target;
    assign target_valid = r_valid;
    assign sched_dir    = r_dir;
    assign pending      = r_pending;

endmodule
`default_nettype wire

// File: tb/tb_elevator_call_scheduler.sv
`default_nettype none
// ============================================================================
// Module      : tb_elevator_call_scheduler
// Description : Scoreboard bench for elevator_call_scheduler (4 floors).
// Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_elevator_call_scheduler;

    typedef struct packed {
        logic [3:0] c;
        logic [1:0] f;
        logic       s;
        logic       e;
    } stim_t;

    typedef struct packed {
        logic [3:0] p;
        logic [1:0] t;
        logic       v;
        logic [1:0] d;
        logic       r;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [3:0] call_btn = 4'b0;
    logic [1:0] current_floor = 2'd0;
    logic       served = 1'b0;
    logic       emerg_recall = 1'b0;
    logic [1:0] target_floor;
    logic       target_valid;
    logic [1:0] sched_dir;
    logic [3:0] pending;
    logic       recall_active;

    exp_t sb[$];
    logic [3:0] m_p;
    logic [1:0] m_t, m_s, m_d;
    logic       m_v, m_r;
    int errors = 0;
    int checks = 0;

    elevator_call_scheduler #(.NUM_FLOORS(4)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .call_btn      (call_btn),
        .current_floor (current_floor),
        .served        (served),
`ifdef EMERG_RECALL_EN
        .emerg_recall  (emerg_recall),
        .recall_active (recall_active),
`endif
        .target_floor  (target_floor),
        .target_valid  (target_valid),
        .sched_dir     (sched_dir),
        .pending       (pending)
    );

`ifndef EMERG_RECALL_EN
    assign recall_active = 1'b0;
`endif

    always #5 clk = ~clk;

    task automatic model_reset();
        m_p = 4'b0; m_t = 2'd0; m_s = 2'd0; m_d = 2'd0; m_v = 1'b0; m_r = 1'b0;
    endtask

    // Reference: per-cycle LOOK decision from the pre-edge pending set.
    task automatic model_step(input logic [3:0] call, input logic [1:0] cur,
                              input logic srv, input logic em);
        logic [3:0] np;
        logic [1:0] ns, nt, nd;
        logic       nv;
        int c, la, hb, nf;
        c = int'(cur);
        if (!rst_n) begin
            model_reset();
        end else begin
            np = m_p | call;
            if (srv) np[c] = 1'b0;
            ns = m_s; nt = m_t; nv = m_v;
            la = -1; hb = -1; nf = -1;
            for (int f = c + 1; f < 4; f++) if (m_p[f] && la < 0) la = f;
            for (int f = c - 1; f >= 0; f--) if (m_p[f] && hb < 0) hb = f;
            for (int d = 1; d < 4; d++) begin
                if (nf < 0 && c - d >= 0 && m_p[c - d]) nf = c - d;
                else if (nf < 0 && c + d < 4 && m_p[c + d]) nf = c + d;
            end
            case (m_s)
                2'd0: begin
                    if (m_p == 4'b0) nv = 1'b0;
                    else if (m_p[c]) begin nt = cur; nv = 1'b1; end
                    else begin nt = 2'(nf); nv = 1'b1; ns = (nf > c) ? 2'd1 : 2'd2; end
                end
                2'd1: begin
                    nv = 1'b1;
                    if (la >= 0) nt = 2'(la);
                    else if (hb >= 0) begin ns = 2'd2; nt = 2'(hb); end
                    else if (m_p[c]) nt = cur;
                    else begin ns = 2'd0; nv = 1'b0; end
                end
                default: begin
                    nv = 1'b1;
                    if (hb >= 0) nt = 2'(hb);
                    else if (la >= 0) begin ns = 2'd1; nt = 2'(la); end
                    else if (m_p[c]) nt = cur;
                    else begin ns = 2'd0; nv = 1'b0; end
                end
            endcase
            nd = ns;
            m_r = em;
            if (em) begin
                np = 4'b0; ns = 2'd0; nt = 2'd0; nv = 1'b1;
                nd = (c == 0) ? 2'd0 : 2'd2;
            end
            m_p = np; m_s = ns; m_t = nt; m_v = nv; m_d = nd;
        end
        sb.push_back('{m_p, m_t, m_v, m_d, m_r});
    endtask

    task automatic cycle(input stim_t st);
        call_btn      = st.c;
        current_floor = st.f;
        served        = st.s;
        emerg_recall  = st.e;
        model_step(st.c, st.f, st.s, st.e);
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        exp_t e;
        rst_n = 1'b0;
        for (int i = 0; i < 2; i++) begin
            cycle('{4'b1111, 2'd0, 1'b0, 1'b0});
            e = sb.pop_front();
            checks++;
            if ({pending, target_floor, target_valid, sched_dir} !== {e.p, e.t, e.v, e.d}) begin
                errors++;
                $display("FAIL reset_sb[%0d] got p=%b t=%0d v=%b d=%b want p=%b t=%0d v=%b d=%b",
                         i, pending, target_floor, target_valid, sched_dir, e.p, e.t, e.v, e.d);
            end
        end
        checks++;
        if ({pending, target_valid, sched_dir} !== 7'b0) begin
            errors++;
            $display("FAIL reset_hold got p=%b v=%b d=%b want p=0000 v=0 d=00", pending, target_valid, sched_dir);
        end
        rst_n = 1'b1;
    endtask

    task automatic test_basic_call();
        stim_t s [0:5];
        exp_t e;
        s = '{'{4'b0100, 2'd0, 1'b0, 1'b0}, '{4'b0000, 2'd0, 1'b0, 1'b0},
              '{4'b0000, 2'd1, 1'b0, 1'b0}, '{4'b0000, 2'd2, 1'b0, 1'b0},
              '{4'b0000, 2'd2, 1'b1, 1'b0}, '{4'b0000, 2'd2, 1'b0, 1'b0}};
        for (int i = 0; i < 6; i++) begin
            cycle(s[i]);
            e = sb.pop_front();
            checks++;
            if ({pending, target_floor, target_valid, sched_dir} !== {e.p, e.t, e.v, e.d}) begin
                errors++;
                $display("FAIL basic_sb[%0d] got p=%b t=%0d v=%b d=%b want p=%b t=%0d v=%b d=%b",
                         i, pending, target_floor, target_valid, sched_dir, e.p, e.t, e.v, e.d);
            end
            if (i == 0) begin
                checks++;
                if (pending !== 4'b0100) begin
                    errors++;
                    $display("FAIL basic_latch got p=%b want p=0100", pending);
                end
            end
            if (i == 1) begin
                checks++;
                if ({target_floor, target_valid, sched_dir} !== {2'd2, 1'b1, 2'b01}) begin
                    errors++;
                    $display("FAIL basic_target got t=%0d v=%b d=%b want t=2 v=1 d=01", target_floor, target_valid, sched_dir);
                end
            end
            if (i == 5) begin
                checks++;
                if ({target_valid, sched_dir} !== 3'b000) begin
                    errors++;
                    $display("FAIL basic_idle got v=%b d=%b want v=0 d=00", target_valid, sched_dir);
                end
            end
        end
    endtask

    task automatic test_look_preempt();
        stim_t s [0:13];
        exp_t e;
        s = '{'{4'b0000, 2'd1, 1'b0, 1'b0}, '{4'b1000, 2'd1, 1'b0, 1'b0},
              '{4'b0000, 2'd1, 1'b0, 1'b0}, '{4'b0100, 2'd1, 1'b0, 1'b0},
              '{4'b0000, 2'd1, 1'b0, 1'b0}, '{4'b0000, 2'd2, 1'b1, 1'b0},
              '{4'b0001, 2'd2, 1'b0, 1'b0}, '{4'b0000, 2'd3, 1'b0, 1'b0},
              '{4'b0000, 2'd3, 1'b1, 1'b0}, '{4'b0000, 2'd2, 1'b0, 1'b0},
              '{4'b0000, 2'd1, 1'b0, 1'b0}, '{4'b0000, 2'd0, 1'b0, 1'b0},
              '{4'b0000, 2'd0, 1'b1, 1'b0}, '{4'b0000, 2'd0, 1'b0, 1'b0}};
        for (int i = 0; i < 14; i++) begin
            cycle(s[i]);
            e = sb.pop_front();
            checks++;
            if ({pending, target_floor, target_valid, sched_dir} !== {e.p, e.t, e.v, e.d}) begin
                errors++;
                $display("FAIL look_sb[%0d] got p=%b t=%0d v=%b d=%b want p=%b t=%0d v=%b d=%b",
                         i, pending, target_floor, target_valid, sched_dir, e.p, e.t, e.v, e.d);
            end
            if (i == 2 || i == 4 || i == 5 || i == 7 || i == 8 || i == 13) begin
                logic [8:0] want;
                case (i)
                    2:       want = {4'b1000, 2'd3, 1'b1, 2'b01};
                    4:       want = {4'b1100, 2'd2, 1'b1, 2'b01};
                    5:       want = {4'b1000, 2'd3, 1'b1, 2'b01};
                    7:       want = {4'b1001, 2'd0, 1'b1, 2'b10};
                    8:       want = {4'b0001, 2'd0, 1'b1, 2'b10};
                    default: want = {4'b0000, 2'd0, 1'b0, 2'b00};
                endcase
                checks++;
                if ({pending, target_floor, target_valid, sched_dir} !== want) begin
                    errors++;
                    $display("FAIL look_step[%0d] got p/t/v/d=%b want %b", i,
                             {pending, target_floor, target_valid, sched_dir}, want);
                end
            end
        end
    endtask

    task automatic test_tie_served();
        stim_t s [0:9];
        exp_t e;
        s = '{'{4'b0000, 2'd1, 1'b0, 1'b0}, '{4'b0101, 2'd1, 1'b0, 1'b0},
              '{4'b0000, 2'd1, 1'b0, 1'b0}, '{4'b0010, 2'd1, 1'b1, 1'b0},
              '{4'b0000, 2'd0, 1'b0, 1'b0}, '{4'b0000, 2'd0, 1'b1, 1'b0},
              '{4'b0000, 2'd1, 1'b0, 1'b0}, '{4'b0000, 2'd2, 1'b0, 1'b0},
              '{4'b0000, 2'd2, 1'b1, 1'b0}, '{4'b0000, 2'd2, 1'b0, 1'b0}};
        for (int i = 0; i < 10; i++) begin
            cycle(s[i]);
            e = sb.pop_front();
            checks++;
            if ({pending, target_floor, target_valid, sched_dir} !== {e.p, e.t, e.v, e.d}) begin
                errors++;
                $display("FAIL tie_sb[%0d] got p=%b t=%0d v=%b d=%b want p=%b t=%0d v=%b d=%b",
                         i, pending, target_floor, target_valid, sched_dir, e.p, e.t, e.v, e.d);
            end
            if (i == 2) begin
                checks++;
                if ({target_floor, target_valid, sched_dir} !== {2'd0, 1'b1, 2'b10}) begin
                    errors++;
                    $display("FAIL tie_lower got t=%0d v=%b d=%b want t=0 v=1 d=10", target_floor, target_valid, sched_dir);
                end
            end
            if (i == 3) begin
                checks++;
                if (pending !== 4'b0101) begin
                    errors++;
                    $display("FAIL press_absorbed got p=%b want p=0101", pending);
                end
            end
            if (i == 9) begin
                checks++;
                if ({pending, target_valid, sched_dir} !== 7'b0) begin
                    errors++;
                    $display("FAIL last_served got p=%b v=%b d=%b want p=0000 v=0 d=00", pending, target_valid, sched_dir);
                end
            end
        end
    endtask

    task automatic test_mid_trip_reset();
        stim_t s [0:2];
        exp_t e;
        s = '{'{4'b0001, 2'd2, 1'b0, 1'b0}, '{4'b0000, 2'd2, 1'b0, 1'b0},
              '{4'b0000, 2'd1, 1'b0, 1'b0}};
        for (int i = 0; i < 3; i++) begin
            cycle(s[i]);
            e = sb.pop_front();
            checks++;
            if ({pending, target_floor, target_valid, sched_dir} !== {e.p, e.t, e.v, e.d}) begin
                errors++;
                $display("FAIL trip_sb[%0d] got p=%b t=%0d v=%b d=%b want p=%b t=%0d v=%b d=%b",
                         i, pending, target_floor, target_valid, sched_dir, e.p, e.t, e.v, e.d);
            end
        end
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        model_reset();
        checks++;
        if ({pending, target_floor, target_valid, sched_dir} !== 9'b0) begin
            errors++;
            $display("FAIL async_reset got p=%b t=%0d v=%b d=%b want all zero", pending, target_floor, target_valid, sched_dir);
        end
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    task automatic test_random();
        exp_t e;
        stim_t st;
        for (int i = 0; i < 300; i++) begin
            st.c = ($urandom_range(0, 2) == 0) ? 4'($urandom) : 4'b0;
            st.f = 2'($urandom_range(0, 3));
            st.s = ($urandom_range(0, 2) == 0);
            st.e = 1'b0;
            cycle(st);
            e = sb.pop_front();
            checks++;
            if ({pending, target_floor, target_valid, sched_dir} !== {e.p, e.t, e.v, e.d}) begin
                errors++;
                $display("FAIL random_sb[%0d] got p=%b t=%0d v=%b d=%b want p=%b t=%0d v=%b d=%b",
                         i, pending, target_floor, target_valid, sched_dir, e.p, e.t, e.v, e.d);
            end
        end
    endtask

`ifdef EMERG_RECALL_EN
    task automatic test_recall();
        stim_t s [0:5];
        exp_t e;
        @(negedge clk);
        rst_n = 1'b0;
        model_reset();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        s = '{'{4'b0011, 2'd3, 1'b0, 1'b0}, '{4'b0000, 2'd3, 1'b0, 1'b1},
              '{4'b1111, 2'd3, 1'b1, 1'b1}, '{4'b0000, 2'd3, 1'b0, 1'b0},
              '{4'b0100, 2'd3, 1'b0, 1'b0}, '{4'b0000, 2'd3, 1'b0, 1'b0}};
        for (int i = 0; i < 6; i++) begin
            cycle(s[i]);
            e = sb.pop_front();
            checks++;
            if ({pending, target_floor, target_valid, sched_dir, recall_active} !== e) begin
                errors++;
                $display("FAIL recall_sb[%0d] got p=%b t=%0d v=%b d=%b r=%b want p=%b t=%0d v=%b d=%b r=%b",
                         i, pending, target_floor, target_valid, sched_dir, recall_active,
                         e.p, e.t, e.v, e.d, e.r);
            end
            if (i == 1 || i == 2 || i == 3 || i == 5) begin
                logic [9:0] want;
                case (i)
                    1:       want = {4'b0000, 2'd0, 1'b1, 2'b10, 1'b1};
                    2:       want = {4'b0000, 2'd0, 1'b1, 2'b10, 1'b1};
                    3:       want = {4'b0000, 2'd0, 1'b0, 2'b00, 1'b0};
                    default: want = {4'b0100, 2'd2, 1'b1, 2'b10, 1'b0};
                endcase
                checks++;
                if ({pending, target_floor, target_valid, sched_dir, recall_active} !== want) begin
                    errors++;
                    $display("FAIL recall_step[%0d] got p/t/v/d/r=%b want %b", i,
                             {pending, target_floor, target_valid, sched_dir, recall_active}, want);
                end
            end
        end
    endtask
`endif

    initial begin
        model_reset();
        test_reset();
        test_basic_call();
        test_look_preempt();
        test_tie_served();
        test_mid_trip_reset();
        test_random();
`ifdef EMERG_RECALL_EN
        test_recall();
`endif
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog got timeout want completion");
        $fatal(1);
    end

endmodule
`default_nettype wire
